// File: rtl/rmii_tx.sv
// RMII transmitter: pulls payload bytes from a show-ahead-less FIFO and sends
// preamble/SFD, payload dibits, optional CRC-32 FCS and the inter-frame gap.
module rmii_tx #(
    parameter bit FCS_EN     = 1'b1,
    parameter int IFG_CYCLES = 48
) (
    input  logic       REF_CLK,
    input  logic       arst_n,
    input  logic       fifo_empty,
    input  logic [7:0] fifo_dout,
    input  logic       fifo_EOD_out,
    output logic       fifo_rden,
    output logic       TX_EN,
    output logic       TXD0,
    output logic       TXD1,
    output logic       tx_busy,
    output logic       tx_abort,
    output logic [2:0] dbg_state
);

    // FIFO handshake: fifo_rden is a one-cycle strobe issued only when
    // fifo_empty was 0 at the deciding edge; fifo_dout/fifo_EOD_out are
    // valid in the cycle after the strobe and are captured at its end.

    typedef enum logic [2:0] {IDLE, PREAMBLE, DATA, FCS, IFG} state_t;
    typedef enum logic [1:0] {END_NEXT, END_LAST, END_UNDERRUN} byte_end_t;

    localparam logic [15:0] PRE_LAST = 16'd32;
    localparam logic [15:0] FCS_LAST = 16'd15;
    // IDLE and the fetch cycle complete the gap, so IFG itself is two shorter.
    localparam logic [15:0] IFG_LAST = 16'(IFG_CYCLES - 3);

    state_t      state, state_n;
    byte_end_t   byte_end, end_n;
    logic [15:0] cnt, cnt_n;
    logic [1:0]  dib, dib_n;
    logic [31:0] crc, crc_n;
    logic [7:0]  byte_q;
    logic        eod_q;
    logic        rd_pend;
    logic        rden_n, tx_en_n, abort_n;
    logic [1:0]  txd_n;

    function automatic logic [31:0] crc_dibit(input logic [31:0] c, input logic [1:0] d);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 2; i++) begin
            if (r[0] ^ d[i]) r = (r >> 1) ^ 32'hEDB88320;
            else             r = r >> 1;
        end
        return r;
    endfunction

    always_comb begin
        state_n = state;
        end_n   = byte_end;
        cnt_n   = cnt;
        dib_n   = dib;
        crc_n   = crc;
        rden_n  = 1'b0;
        tx_en_n = 1'b0;
        abort_n = 1'b0;
        txd_n   = 2'b00;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    state_n = PREAMBLE;
                    cnt_n   = '0;
                    rden_n  = 1'b1;
                end
            end
            PREAMBLE: begin
                // cnt 0 is the fetch cycle; cnt 1..32 are the preamble dibits.
                tx_en_n = 1'b1;
                if (cnt != PRE_LAST) begin
                    cnt_n = cnt + 16'd1;
                    if (cnt == PRE_LAST - 16'd1) begin
                        txd_n = 2'b11;
                        crc_n = '1;
                    end else begin
                        txd_n = 2'b01;
                    end
                end else begin
                    state_n = DATA;
                    dib_n   = 2'd0;
                    txd_n   = byte_q[1:0];
                    crc_n   = crc_dibit(crc, byte_q[1:0]);
                end
            end
            DATA: begin
                if (dib != 2'd3) begin
                    tx_en_n = 1'b1;
                    dib_n   = dib + 2'd1;
                    txd_n   = byte_q[{dib_n, 1'b0} +: 2];
                    crc_n   = crc_dibit(crc, txd_n);
                    if (dib == 2'd0) begin
                        if (eod_q) begin
                            end_n = END_LAST;
                        end else if (!fifo_empty) begin
                            rden_n = 1'b1;
                            end_n  = END_NEXT;
                        end else begin
                            end_n = END_UNDERRUN;
                        end
                    end
                end else begin
                    case (byte_end)
                        END_NEXT: begin
                            tx_en_n = 1'b1;
                            dib_n   = 2'd0;
                            txd_n   = byte_q[1:0];
                            crc_n   = crc_dibit(crc, byte_q[1:0]);
                        end
                        END_LAST: begin
                            cnt_n = '0;
                            if (FCS_EN) begin
                                state_n = FCS;
                                tx_en_n = 1'b1;
                                txd_n   = ~crc[1:0];
                                crc_n   = crc >> 2;
                            end else begin
                                state_n = IFG;
                            end
                        end
                        default: begin
                            state_n = IFG;
                            cnt_n   = '0;
                            abort_n = 1'b1;
                        end
                    endcase
                end
            end
            FCS: begin
                if (cnt != FCS_LAST) begin
                    cnt_n   = cnt + 16'd1;
                    tx_en_n = 1'b1;
                    txd_n   = ~crc[1:0];
                    crc_n   = crc >> 2;
                end else begin
                    state_n = IFG;
                    cnt_n   = '0;
                end
            end
            IFG: begin
                if (cnt == IFG_LAST) state_n = IDLE;
                else                 cnt_n   = cnt + 16'd1;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge REF_CLK or negedge arst_n) begin
        if (!arst_n) begin
            state     <= IDLE;
            byte_end  <= END_NEXT;
            cnt       <= '0;
            dib       <= '0;
            crc       <= '0;
            byte_q    <= '0;
            eod_q     <= 1'b0;
            rd_pend   <= 1'b0;
            fifo_rden <= 1'b0;
            TX_EN     <= 1'b0;
            TXD0      <= 1'b0;
            TXD1      <= 1'b0;
            tx_abort  <= 1'b0;
        end else begin
            state     <= state_n;
            byte_end  <= end_n;
            cnt       <= cnt_n;
            dib       <= dib_n;
            crc       <= crc_n;
            fifo_rden <= rden_n;
            TX_EN     <= tx_en_n;
            TXD0      <= txd_n[0];
            TXD1      <= txd_n[1];
            tx_abort  <= abort_n;
            rd_pend   <= fifo_rden;
            if (rd_pend) begin
                byte_q <= fifo_dout;
                eod_q  <= fifo_EOD_out;
            end
        end
    end

    assign tx_busy   = (state != IDLE);
    assign dbg_state = state;

endmodule
